// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS window, TX FIFO and 8N1 serialiser.
// Define UART_PARITY_EN to add an even-parity bit (8E1 frame).
module mmio_uart_tx #(
   parameter int          CLK_PER_BIT = 434,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
`ifdef UART_PARITY_EN
   localparam logic PARITY_PRESENT = 1'b1;
`else
   localparam logic PARITY_PRESENT = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] baud_r, baud_s;
   logic [2:0]    bit_r, bit_s;
   logic [7:0]    shift_r, shift_s;
   logic          par_r, par_s;
   logic          txd_r, txd_s;
   logic          irq_r, irq_s;
   logic          ovf_r;
   logic [AW:0]   wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic          full_s, empty_s, busy_s, pop_s, push_req_s, push_ok_s, drop_s, clr_ovf_s;
   logic [31:0]   status_s;
   logic [7:0]    head_s;

   assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty_s    = (wr_ptr_r == rd_ptr_r);
   assign busy_s     = (state_r != ST_IDLE);
   assign head_s     = fifo_mem[rd_ptr_r[AW-1:0]];
   assign push_req_s = sel & we & ~addr[2];
   assign clr_ovf_s  = sel & we & addr[2];
   // A full FIFO still accepts a store on the cycle the shifter pops its head.
   assign push_ok_s  = push_req_s & (~full_s | pop_s);
   assign drop_s     = push_req_s & full_s & ~pop_s;
   assign wr_ptr_s   = wr_ptr_r + (AW+1)'(push_ok_s);
   assign rd_ptr_s   = rd_ptr_r + (AW+1)'(pop_s);
   assign status_s   = {27'h0, PARITY_PRESENT, ovf_r, busy_s, empty_s, full_s};
   assign txd        = txd_r;
   assign irq        = irq_r;

   // Load data: STATUS only; TXDATA and deselected reads return zero.
   always_comb begin
      rdata = 32'h0;
      if (sel && addr[2]) begin
         rdata = status_s;
      end else begin
         rdata = 32'h0;
      end
   end

   // Frame sequencer next-state, pop decision and line level.
   always_comb begin
      state_s = state_r;
      baud_s  = baud_r;
      bit_s   = bit_r;
      shift_s = shift_r;
      par_s   = par_r;
      pop_s   = 1'b0;
      txd_s   = 1'b1;
      case (state_r)
         ST_IDLE: begin
            txd_s = 1'b1;
            if (!empty_s) begin
               pop_s   = 1'b1;
               shift_s = head_s;
               par_s   = ^head_s;
               baud_s  = '0;
               bit_s   = 3'd0;
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            txd_s = 1'b0;
            if (baud_r == BAUD_LAST) begin
               baud_s  = '0;
               bit_s   = 3'd0;
               state_s = ST_DATA;
            end else begin
               baud_s = baud_r + CW'(1);
            end
         end
         ST_DATA: begin
            txd_s = shift_r[0];
            if (baud_r == BAUD_LAST) begin
               baud_s  = '0;
               shift_s = {1'b0, shift_r[7:1]};
               if (bit_r == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_s = ST_PARITY;
`else
                  state_s = ST_STOP;
`endif
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               baud_s = baud_r + CW'(1);
            end
         end
         ST_PARITY: begin
            txd_s = par_r;
            if (baud_r == BAUD_LAST) begin
               baud_s  = '0;
               state_s = ST_STOP;
            end else begin
               baud_s = baud_r + CW'(1);
            end
         end
         ST_STOP: begin
            txd_s = 1'b1;
            if (baud_r == BAUD_LAST) begin
               baud_s  = '0;
               state_s = ST_IDLE;
            end else begin
               baud_s = baud_r + CW'(1);
            end
         end
         default: begin
            txd_s   = 1'b1;
            baud_s  = '0;
            state_s = ST_IDLE;
         end
      endcase
      irq_s = (wr_ptr_s == rd_ptr_s) && (state_s == ST_IDLE);
   end

   // Sequencer, line and interrupt registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         baud_r  <= '0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         par_r   <= 1'b0;
         txd_r   <= 1'b1;
         irq_r   <= 1'b1;
      end else begin
         state_r <= state_s;
         baud_r  <= baud_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         par_r   <= par_s;
         txd_r   <= txd_s;
         irq_r   <= irq_s;
      end
   end

   // FIFO storage, pointers and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         ovf_r    <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= 8'h00;
         end
      end else begin
         wr_ptr_r <= wr_ptr_s;
         rd_ptr_r <= rd_ptr_s;
         if (push_ok_s) begin
            fifo_mem[wr_ptr_r[AW-1:0]] <= wdata[7:0];
         end
         if (clr_ovf_s) begin
            ovf_r <= 1'b0;
         end else if (drop_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

`ifdef UART_PARITY_EN
   logic unused_s;
   assign unused_s = ^{addr[31:3], addr[1:0], wdata[31:8], BASE_ADDR};
`else
   logic unused_s;
   assign unused_s = ^{addr[31:3], addr[1:0], wdata[31:8], BASE_ADDR, par_r};
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised bench for mmio_uart_tx against a frame-schedule reference model.
module tb_mmio_uart_tx;
   localparam int C = 4;
   localparam int D = 8;
`ifdef UART_PARITY_EN
   localparam int   F   = 11;
   localparam logic PAR = 1'b1;
`else
   localparam int   F   = 10;
   localparam logic PAR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sel = 1'b0;
   logic        we  = 1'b0;
   logic [31:0] addr  = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        txd, irq;

   mmio_uart_tx #(.CLK_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(32'h1000_0000)) dut (
      .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
      .wdata(wdata), .rdata(rdata), .txd(txd), .irq(irq)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   // Per accepted byte: push edge, pop edge, edge where txd falls, payload.
   int         t_q[$];
   int         p_q[$];
   int         s_q[$];
   logic [7:0] b_q[$];
   logic       ovf_m = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic exp_txd(input int e);
      int idx;
      logic [7:0] b;
      for (int k = 0; k < s_q.size(); k++) begin
         if (e >= s_q[k] && e < s_q[k] + F*C) begin
            idx = (e - s_q[k]) / C;
            b = b_q[k];
            if (idx == 0) return 1'b0;
            if (idx <= 8) return b[idx-1];
            if (idx == 9 && F == 11) return ^b;
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_status(input int e);
      int occ;
      logic busy;
      occ = 0;
      busy = 1'b0;
      for (int k = 0; k < p_q.size(); k++) begin
         if (t_q[k] <= e && p_q[k] > e) occ++;
         if (p_q[k] <= e && e < p_q[k] + F*C) busy = 1'b1;
      end
      return {27'h0, PAR, ovf_m, busy, (occ == 0), (occ == D)};
   endfunction

   task automatic model_edge(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d, input int e);
      int n;
      int sn;
      if (s && w && !a[2]) begin
         n = 0;
         for (int k = 0; k < p_q.size(); k++) if (p_q[k] > e) n++;
         if (n < D) begin
            sn = e + 2;
            if (s_q.size() > 0 && s_q[$] + F*C + 1 > sn) sn = s_q[$] + F*C + 1;
            t_q.push_back(e);
            p_q.push_back(sn - 1);
            s_q.push_back(sn);
            b_q.push_back(d[7:0]);
         end else begin
            ovf_m = 1'b1;
         end
      end else if (s && w && a[2]) begin
         ovf_m = 1'b0;
      end
   endtask

   // Called just after a rising edge: drive, check at the falling edge, advance model.
   task automatic step(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
      sel = s; we = w; addr = a; wdata = d;
      @(negedge clk);
      check_val("txd", {31'h0, txd}, {31'h0, exp_txd(cyc)});
      check_val("irq", {31'h0, irq}, {31'h0, (exp_status(cyc) & 32'h6) == 32'h2});
      if (!w) check_val("rdata", rdata, (s && a[2]) ? exp_status(cyc) : 32'h0);
      @(posedge clk);
      cyc++;
      model_edge(s, w, a, d, cyc);
      #1;
   endtask

   task automatic store(input logic [7:0] b);
      logic [31:0] a;
      a = $urandom;
      a[2] = 1'b0;
      step(1'b1, 1'b1, a, {$urandom} & 32'hFFFF_FF00 | {24'h0, b});
   endtask

   task automatic rd_status(input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = $urandom;
         a[2] = 1'b1;
         step(1'b1, 1'b0, a, 32'h0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; sel = 1'b1; we = 1'b0; addr = 32'h4;
      #1;
      check_val("rst_txd", {31'h0, txd}, 32'h1);
      check_val("rst_irq", {31'h0, irq}, 32'h1);
      check_val("rst_status", rdata, {27'h0, PAR, 4'h2});
      @(negedge clk);
      @(posedge clk); cyc++;
      @(negedge clk);
      check_val("rst_hold_txd", {31'h0, txd}, 32'h1);
      check_val("rst_hold_status", rdata, {27'h0, PAR, 4'h2});
      @(posedge clk); cyc++;
      @(negedge clk);
      rst = 1'b1;
      t_q.delete(); p_q.delete(); s_q.delete(); b_q.delete();
      ovf_m = 1'b0;
      @(posedge clk); cyc++;
      #1;
   endtask

   initial begin
      int r;
      logic [31:0] a;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      cyc = 0;
      #1;
      rd_status(5);
      // Single 0x55 frame, then two back-to-back frames.
      store(8'h55);
      rd_status(45);
      store(8'hA5);
      store(8'h3C);
      rd_status(90);
      // Ten back-to-back stores, then keep storing while full, then clear overflow.
      for (int i = 0; i < 10; i++) store(8'(i));
      rd_status(3);
      for (int i = 0; i < 50; i++) store(8'(8'hC0 + i));
      rd_status(2);
      step(1'b1, 1'b1, 32'h1000_0004, 32'hFFFF_FFFF);
      rd_status(12 * F * C);
      // Store landing while the last frame is in its stop bit.
      store(8'h5A);
      rd_status(F*C - 2);
      store(8'hE1);
      rd_status(F*C + 10);
      store(8'h07);
      store(8'h03);
      rd_status(2*F*C + 5);
      // Randomised traffic.
      for (int i = 0; i < 700; i++) begin
         r = $urandom_range(0, 99);
         a = $urandom;
         if (r < 3) begin
            for (int j = 0; j < 10; j++) store(8'($urandom));
         end else if (r < 15) begin
            store(8'($urandom));
         end else if (r < 18) begin
            a[2] = 1'b1;
            step(1'b1, 1'b1, a, $urandom);
         end else if (r < 22) begin
            a[2] = 1'b0;
            step(1'b1, 1'b0, a, 32'h0);
         end else if (r < 27) begin
            step(1'b0, 1'($urandom), a, $urandom);
         end else begin
            rd_status(1);
         end
      end
      rd_status(14 * F * C);
      // Reset in the middle of a frame with more bytes queued.
      store(8'h81);
      store(8'h7E);
      rd_status(15);
      do_reset();
      rd_status(F*C + 5);
      store(8'h42);
      rd_status(F*C + 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
